inter_clk_edge_gen: RTL and testbench
=====================================

INTER_CLK_EDGE_GEN -- requirements
Module: inter_clk_edge_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..4.
REQ-002 Parameter MIN_HIGH, default 2: minimum accepted high width, in CLK_50 cycles.
REQ-003 Parameter MIN_LOW, default 2: minimum accepted low width, in CLK_50 cycles.
REQ-004 Parameter TIMEOUT, default 16'hFFFF: high-width limit before the stuck condition is declared.
REQ-005 Parameter DRIVE_LEN, default 4: drive_en pulse length, in cycles, range 1..255.
REQ-006 Port CLK_50, in, 1: the only clock; all flops are rising-edge.
REQ-007 Port rst_n, in, 1: reset, asynchronous assert, active-low.
REQ-008 Port CLK_inter, in, 1: MCU-generated clock, asynchronous to CLK_50.
REQ-009 Port clk_inter_d, out, 1: synchronized CLK_inter level.
REQ-010 Port clk_rise, out, 1: one-cycle strobe on a synchronized rising edge.
REQ-011 Port clk_fall, out, 1: one-cycle strobe on a synchronized falling edge.
REQ-012 Port saw_rise, out, 1: high while the FSM is in state HIGH.
REQ-013 Port full_pulse, out, 1: one-cycle strobe when a qualified high pulse completes.
REQ-014 Port drive_en, out, 1: lock drive window, consumed by cmb_0/drive_en.
REQ-015 Port pulse_width, out, 16: high width of the last qualified pulse, in cycles.
REQ-016 Port glitch_cnt, out, 8: count of rejected pulses, saturating.
REQ-017 Port stuck, out, 1: sticky timeout flag.

Function
REQ-018 CLK_inter SHALL pass through SYNC_STAGES flops; clk_inter_d SHALL be the last stage.
- Input change reaches clk_inter_d SYNC_STAGES cycles after first sampling.
REQ-019 A registered copy prev SHALL hold the previous clk_inter_d.
- clk_rise = clk_inter_d & ~prev, registered, so it appears 1 cycle after clk_inter_d rises.
- clk_fall is formed the same way from the opposite edge.
- clk_rise and clk_fall are never high in the same cycle.
REQ-020 The FSM SHALL have states IDLE, HIGH, LOW, STUCK and a 16-bit width counter cnt.
- cnt saturates at 16'hFFFF.
REQ-021 IDLE: on clk_rise, go to HIGH with cnt=1; otherwise hold.
REQ-022 HIGH: cnt increments each cycle.
- On clk_fall with cnt>=MIN_HIGH: full_pulse=1 for one cycle, pulse_width<=cnt, go to LOW with cnt=1.
- On clk_fall with cnt<MIN_HIGH: glitch_cnt increments, go to IDLE, pulse_width unchanged.
REQ-023 HIGH with cnt==TIMEOUT and no clk_fall: set stuck, go to STUCK.
- TIMEOUT and fall in the same cycle: the fall wins.
REQ-024 STUCK: on clk_fall, go to LOW with cnt=1; full_pulse is never asserted.
REQ-025 LOW: cnt increments.
- cnt>=MIN_LOW with no clk_rise: go to IDLE.
- clk_rise with cnt>=MIN_LOW: go directly to HIGH with cnt=1.
- clk_rise with cnt<MIN_LOW: glitch_cnt increments, go to IDLE, rise discarded.
REQ-026 drive_en SHALL assert the cycle after full_pulse and hold exactly DRIVE_LEN cycles.
- A full_pulse arriving during an active window restarts the window at DRIVE_LEN.
REQ-027 glitch_cnt SHALL saturate at 8'hFF.
REQ-028 stuck SHALL clear only on reset.
REQ-029 saw_rise SHALL be a registered decode of state==HIGH.
REQ-030 All outputs SHALL be registered; no combinational path from CLK_inter to any output.

Reset
REQ-031 On rst_n low, all of the following clear immediately, regardless of CLK_50:
- synchronizer, prev, cnt, drive_en window counter;
- clk_inter_d, clk_rise, clk_fall, saw_rise, full_pulse, drive_en, pulse_width, glitch_cnt, stuck;
- FSM state returns to IDLE.
REQ-032 Reset asserted mid-pulse or mid-drive_en SHALL abort with no trailing strobes.
REQ-033 Release SHALL take effect on the next CLK_50 edge.
- A CLK_inter already high at release yields clk_rise once synchronized.
- That rise is accepted normally.

Verification
REQ-034 Defaults; CLK_inter high 10 cycles, then low 10.
- clk_rise at cycle 3 after the input edge.
- full_pulse at cycle 3 after the fall; pulse_width=10.
- drive_en high for exactly 4 cycles.
REQ-035 CLK_inter high 1 cycle (synchronized width 1).
- glitch_cnt=1, no full_pulse, no drive_en, FSM returns to IDLE.
REQ-036 Back-to-back pulses: high 5, low 1, high 5.
- First pulse gives full_pulse with pulse_width=5.
- Second rise is discarded: glitch_cnt=1, one drive_en window only.
REQ-037 TIMEOUT=20, CLK_inter held high 40 cycles, then low.
- stuck=1 at cnt=20, saw_rise drops, no full_pulse.
- Next valid pulse still qualifies; stuck stays 1.
REQ-038 Two qualified pulses with full_pulse strobes 3 cycles apart, DRIVE_LEN=4.
- drive_en continuous for 3+4 cycles.
REQ-039 rst_n low at cycle 2 of drive_en and mid-HIGH.
- All outputs 0 immediately; after release, a 6-cycle pulse gives pulse_width=6.

Source files
------------

// File: rtl/inter_clk_edge_gen.sv
// inter_clk_edge_gen: synchronizes CLK_inter into CLK_50, qualifies its pulses and times the drive_en window.
module inter_clk_edge_gen #(
  parameter int          SYNC_STAGES = 2,
  parameter int          MIN_HIGH    = 2,
  parameter int          MIN_LOW     = 2,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF,
  parameter int          DRIVE_LEN   = 4
) (
  input  logic        CLK_50,
  input  logic        rst_n,
  input  logic        CLK_inter,
  output logic        clk_inter_d,
  output logic        clk_rise,
  output logic        clk_fall,
  output logic        saw_rise,
  output logic        full_pulse,
  output logic        drive_en,
  output logic [15:0] pulse_width,
  output logic [7:0]  glitch_cnt,
  output logic        stuck
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [15:0]            cnt;
  logic [7:0]             dcnt;
  logic                   rise_w, fall_w;
  logic [15:0]            cnt_inc;
  logic [7:0]             glitch_inc;
  assign clk_inter_d = sync[SYNC_STAGES-1];
  assign rise_w      = clk_inter_d & ~prev;
  assign fall_w      = ~clk_inter_d & prev;
  assign cnt_inc     = cnt == 16'hFFFF ? cnt : cnt + 16'd1;
  assign glitch_inc  = glitch_cnt == 8'hFF ? glitch_cnt : glitch_cnt + 8'd1;
  // The FSM acts on the same edge term that clk_rise/clk_fall register, so it runs one cycle ahead of those strobes.
  always_ff @(posedge CLK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync        <= '0;
      prev        <= 1'b0;
      cnt         <= '0;
      dcnt        <= '0;
      clk_rise    <= 1'b0;
      clk_fall    <= 1'b0;
      saw_rise    <= 1'b0;
      full_pulse  <= 1'b0;
      drive_en    <= 1'b0;
      pulse_width <= '0;
      glitch_cnt  <= '0;
      stuck       <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], CLK_inter};
      prev       <= clk_inter_d;
      clk_rise   <= rise_w;
      clk_fall   <= fall_w;
      full_pulse <= 1'b0;
      drive_en   <= full_pulse || dcnt > 8'd1;
      dcnt       <= full_pulse ? 8'(DRIVE_LEN) : dcnt - {7'd0, dcnt != 8'd0};
      case (state)
        IDLE: if (rise_w) begin
          state    <= HIGH;
          saw_rise <= 1'b1;
          cnt      <= 16'd1;
        end
        HIGH: if (fall_w) begin
          saw_rise <= 1'b0;
          if (cnt >= 16'(MIN_HIGH)) begin
            full_pulse  <= 1'b1;
            pulse_width <= cnt;
            state       <= LOW;
            cnt         <= 16'd1;
          end else begin
            glitch_cnt <= glitch_inc;
            state      <= IDLE;
          end
        end else if (cnt == TIMEOUT) begin
          stuck    <= 1'b1;
          saw_rise <= 1'b0;
          state    <= STUCK;
        end else cnt <= cnt_inc;
        STUCK: if (fall_w) begin
          state <= LOW;
          cnt   <= 16'd1;
        end
        LOW: if (rise_w) begin
          if (cnt >= 16'(MIN_LOW)) begin
            state    <= HIGH;
            saw_rise <= 1'b1;
            cnt      <= 16'd1;
          end else begin
            glitch_cnt <= glitch_inc;
            state      <= IDLE;
          end
        end else if (cnt >= 16'(MIN_LOW)) state <= IDLE;
        else cnt <= cnt_inc;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inter_clk_edge_gen.sv
// tb_inter_clk_edge_gen: two differently parameterized instances checked every cycle against a behavioural model.
module tb_inter_clk_edge_gen;
  logic clk = 1'b0, rst_n = 1'b1, clk_inter = 1'b0;
  logic [1:0]  o_d, o_rise, o_fall, o_saw, o_full, o_drive, o_stuck;
  logic [15:0] o_pw [2];
  logic [7:0]  o_gl [2];
  int errors = 0, checks = 0;
  int p_s [2] = '{2, 3};
  int p_mh[2] = '{2, 1};
  int p_ml[2] = '{2, 1};
  int p_to[2] = '{20, 20};
  int p_dl[2] = '{4, 4};
  localparam int M_IDLE = 0, M_HIGH = 1, M_LOW = 2, M_STUCK = 3;
  int hist[2], md[2], mp[2], er[2], ef[2], st[2], w[2], efu[2], epw[2], egl[2], est[2], dlast[2], cyc[2];
  int full_a, drive_a, drive_b, run_b, max_run_b;
  bit v;
  always #5 clk = ~clk;
  inter_clk_edge_gen #(.TIMEOUT(16'd20)) dut_a (
    .CLK_50(clk), .rst_n(rst_n), .CLK_inter(clk_inter), .clk_inter_d(o_d[0]), .clk_rise(o_rise[0]),
    .clk_fall(o_fall[0]), .saw_rise(o_saw[0]), .full_pulse(o_full[0]), .drive_en(o_drive[0]),
    .pulse_width(o_pw[0]), .glitch_cnt(o_gl[0]), .stuck(o_stuck[0]));
  inter_clk_edge_gen #(.SYNC_STAGES(3), .MIN_HIGH(1), .MIN_LOW(1), .TIMEOUT(16'd20)) dut_b (
    .CLK_50(clk), .rst_n(rst_n), .CLK_inter(clk_inter), .clk_inter_d(o_d[1]), .clk_rise(o_rise[1]),
    .clk_fall(o_fall[1]), .saw_rise(o_saw[1]), .full_pulse(o_full[1]), .drive_en(o_drive[1]),
    .pulse_width(o_pw[1]), .glitch_cnt(o_gl[1]), .stuck(o_stuck[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      hist[i] = 0; md[i] = 0; mp[i] = 0; er[i] = 0; ef[i] = 0; st[i] = M_IDLE;
      w[i] = 0; efu[i] = 0; epw[i] = 0; egl[i] = 0; est[i] = 0; dlast[i] = -1;
    end
  endtask
  // One CLK_50 edge of the reference behaviour, using the edge terms seen before the edge.
  task automatic step(input int i, input bit in);
    int rise, fall, fu;
    rise = int'(md[i] == 1 && mp[i] == 0);
    fall = int'(md[i] == 0 && mp[i] == 1);
    fu = efu[i];
    cyc[i]++;
    hist[i] = ((hist[i] << 1) | int'(in)) & 15;
    mp[i] = md[i];
    md[i] = (hist[i] >> (p_s[i] - 1)) & 1;
    er[i] = rise; ef[i] = fall; efu[i] = 0;
    if (fu != 0) dlast[i] = cyc[i] + p_dl[i] - 1;
    if (st[i] == M_IDLE) begin
      if (rise != 0) begin st[i] = M_HIGH; w[i] = 1; end
    end else if (st[i] == M_HIGH) begin
      if (fall != 0) begin
        if (w[i] >= p_mh[i]) begin efu[i] = 1; epw[i] = w[i]; st[i] = M_LOW; w[i] = 1; end
        else begin egl[i] = egl[i] < 255 ? egl[i] + 1 : 255; st[i] = M_IDLE; end
      end else if (w[i] == p_to[i]) begin est[i] = 1; st[i] = M_STUCK; end
      else w[i] = w[i] < 65535 ? w[i] + 1 : 65535;
    end else if (st[i] == M_STUCK) begin
      if (fall != 0) begin st[i] = M_LOW; w[i] = 1; end
    end else begin
      if (rise != 0) begin
        if (w[i] >= p_ml[i]) begin st[i] = M_HIGH; w[i] = 1; end
        else begin egl[i] = egl[i] < 255 ? egl[i] + 1 : 255; st[i] = M_IDLE; end
      end else if (w[i] >= p_ml[i]) st[i] = M_IDLE;
      else w[i] = w[i] + 1;
    end
  endtask
  task automatic compare_all(input int i);
    string t;
    t = i != 0 ? "B" : "A";
    chk({t, ".clk_inter_d"}, 32'(o_d[i]), 32'(md[i]));
    chk({t, ".clk_rise"}, 32'(o_rise[i]), 32'(er[i]));
    chk({t, ".clk_fall"}, 32'(o_fall[i]), 32'(ef[i]));
    chk({t, ".saw_rise"}, 32'(o_saw[i]), 32'(st[i] == M_HIGH));
    chk({t, ".full_pulse"}, 32'(o_full[i]), 32'(efu[i]));
    chk({t, ".drive_en"}, 32'(o_drive[i]), 32'(cyc[i] <= dlast[i]));
    chk({t, ".pulse_width"}, 32'(o_pw[i]), 32'(epw[i]));
    chk({t, ".glitch_cnt"}, 32'(o_gl[i]), 32'(egl[i]));
    chk({t, ".stuck"}, 32'(o_stuck[i]), 32'(est[i]));
  endtask
  task automatic tick(input bit val);
    @(negedge clk);
    clk_inter = val;
    @(posedge clk);
    if (rst_n) begin
      step(0, val);
      step(1, val);
    end
    #1;
    compare_all(0);
    compare_all(1);
    if (o_full[0]) full_a++;
    if (o_drive[0]) drive_a++;
    if (o_drive[1]) begin
      drive_b++;
      run_b++;
      if (run_b > max_run_b) max_run_b = run_b;
    end else run_b = 0;
  endtask
  task automatic hold(input bit val, input int n);
    repeat (n) tick(val);
  endtask
  task automatic clr();
    full_a = 0; drive_a = 0; drive_b = 0; run_b = 0; max_run_b = 0;
  endtask
  // Asserts reset between clock edges so the asynchronous clear is observed before any edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    mreset();
    #1;
    compare_all(0);
    compare_all(1);
    chk("rst.saw_rise", 32'(o_saw[0]), 32'd0);
    chk("rst.drive_en", 32'(o_drive[0]), 32'd0);
    chk("rst.pulse_width", 32'(o_pw[0]), 32'd0);
    chk("rst.stuck", 32'(o_stuck[0]), 32'd0);
    hold(clk_inter, 2);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    mreset();
    cyc[0] = 0; cyc[1] = 0;
    clr();
    @(posedge clk);
    #1;
    do_reset();
    hold(1'b0, 5);
    clr();
    tick(1'b1);
    tick(1'b1);
    chk("edge.rise_early", 32'(o_rise[0]), 32'd0);
    tick(1'b1);
    chk("edge.rise_cycle3", 32'(o_rise[0]), 32'd1);
    hold(1'b1, 7);
    tick(1'b0);
    tick(1'b0);
    chk("edge.full_early", 32'(o_full[0]), 32'd0);
    tick(1'b0);
    chk("edge.full_cycle3", 32'(o_full[0]), 32'd1);
    hold(1'b0, 10);
    chk("edge.pulse_width", 32'(o_pw[0]), 32'd10);
    chk("edge.drive_cycles", 32'(drive_a), 32'd4);
    clr();
    tick(1'b1);
    hold(1'b0, 10);
    chk("glitch.count", 32'(o_gl[0]), 32'd1);
    chk("glitch.full", 32'(full_a), 32'd0);
    chk("glitch.drive", 32'(drive_a), 32'd0);
    chk("glitch.saw_rise", 32'(o_saw[0]), 32'd0);
    do_reset();
    clr();
    hold(1'b0, 4);
    hold(1'b1, 5);
    tick(1'b0);
    hold(1'b1, 5);
    hold(1'b0, 12);
    chk("b2b.pulse_width", 32'(o_pw[0]), 32'd5);
    chk("b2b.glitch", 32'(o_gl[0]), 32'd1);
    chk("b2b.full", 32'(full_a), 32'd1);
    chk("b2b.drive", 32'(drive_a), 32'd4);
    do_reset();
    clr();
    hold(1'b0, 5);
    hold(1'b1, 4);
    tick(1'b0);
    hold(1'b1, 2);
    hold(1'b0, 12);
    chk("restart.drive_run", 32'(max_run_b), 32'd7);
    chk("restart.drive_total", 32'(drive_b), 32'd7);
    do_reset();
    clr();
    hold(1'b0, 4);
    hold(1'b1, 40);
    chk("timeout.stuck", 32'(o_stuck[0]), 32'd1);
    chk("timeout.saw_rise", 32'(o_saw[0]), 32'd0);
    chk("timeout.full", 32'(full_a), 32'd0);
    hold(1'b0, 6);
    hold(1'b1, 6);
    hold(1'b0, 6);
    chk("timeout.next_width", 32'(o_pw[0]), 32'd6);
    chk("timeout.next_full", 32'(full_a), 32'd1);
    chk("timeout.sticky", 32'(o_stuck[0]), 32'd1);
    do_reset();
    hold(1'b0, 4);
    hold(1'b1, 6);
    hold(1'b0, 5);
    chk("abort.in_drive", 32'(o_drive[0]), 32'd1);
    do_reset();
    clr();
    hold(1'b0, 3);
    hold(1'b1, 6);
    hold(1'b0, 6);
    chk("abort.pulse_width", 32'(o_pw[0]), 32'd6);
    hold(1'b1, 5);
    chk("abort.mid_high", 32'(o_saw[0]), 32'd1);
    do_reset();
    clr();
    hold(1'b1, 6);
    hold(1'b0, 6);
    chk("release_high.width", 32'(o_pw[0]), 32'd6);
    chk("release_high.full", 32'(full_a), 32'd1);
    do_reset();
    repeat (260) begin
      tick(1'b1);
      hold(1'b0, 3);
    end
    chk("glitch.saturate", 32'(o_gl[0]), 32'd255);
    do_reset();
    v = 1'b0;
    repeat (250) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      v = ~v;
      hold(v, $urandom_range(0, 9) == 0 ? int'($urandom_range(18, 30)) : int'($urandom_range(1, 6)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
